power_seq: RTL and testbench

POWER_SEQ -- requirements
Module: power_seq

---
 rtl/power_seq_pkg.sv | 38 +++
 rtl/power_seq_if.sv | 25 ++
 rtl/power_seq_rom.sv | 11 +
 rtl/power_seq.sv | 144 ++++++++++++++
 tb/tb_power_seq.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/power_seq_pkg.sv
// Shared definitions for the power sequencer: state encodings, step table, timeout limit.
package power_seq_def;

  localparam int unsigned NUM_STEPS = 4;
  localparam int unsigned STEP_W    = 2;
  localparam int unsigned CTRL_W    = 4;
  localparam int unsigned MS_W      = 12;
  localparam int unsigned TMO_W     = 24;

  localparam logic [STEP_W-1:0] LAST_STEP      = STEP_W'(NUM_STEPS - 1);
  localparam logic [TMO_W-1:0]  TIMEOUT_CYCLES = 24'hFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_GAP  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [MS_W-1:0]   ms;
  } step_t;

  // Rail pattern and delay for each step of the power-up sequence
  function automatic step_t step_lookup(input logic [STEP_W-1:0] idx);
    step_t s;
    case (idx)
      2'd0:    s = '{ctrl: 4'b0001, ms: 12'd1};
      2'd1:    s = '{ctrl: 4'b0011, ms: 12'd100};
      2'd2:    s = '{ctrl: 4'b0111, ms: 12'd20};
      default: s = '{ctrl: 4'b1111, ms: 12'd100};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/power_seq_if.sv
// Control/status bundle between the power sequencer and its controller/delay generator.
interface power_seq_if;
  import power_seq_def::*;

  logic              start;
  logic              abort;
  logic              delay_fin;
  logic              delay_en;
  logic [MS_W-1:0]   delay_ms;
  logic [CTRL_W-1:0] ctrl_out;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, abort, delay_fin,
    input  delay_en, delay_ms, ctrl_out, busy, done, err
  );

  modport slave (
    input  start, abort, delay_fin,
    output delay_en, delay_ms, ctrl_out, busy, done, err
  );

endinterface

// File: rtl/power_seq_rom.sv
// Combinational step table lookup: step index -> {ctrl_out, delay_ms}.
module power_seq_rom
  import power_seq_def::*;
(
  input  logic [STEP_W-1:0] i_idx,
  output step_t             o_step_c
);

  assign o_step_c = step_lookup(i_idx);

endmodule

// File: rtl/power_seq.sv
// Four-step power rail sequencer driving an external millisecond delay generator.
// Optional request timeout to ERR is enabled by defining POWER_SEQ_TIMEOUT_EN.
module power_seq (
  input  logic       clk,
  input  logic       rst_n,
  power_seq_if.slave bus
);
  import power_seq_def::*;

  state_e            r_state, w_state_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt, w_rom_idx;
  logic              r_delay_en, w_delay_en_nxt;
  logic [MS_W-1:0]   r_delay_ms, w_delay_ms_nxt;
  logic [CTRL_W-1:0] r_ctrl, w_ctrl_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic              w_tmo_hit;
  step_t             w_rom;

  // GAP preloads the following step; IDLE always loads step 0
  assign w_rom_idx = (r_state == ST_GAP) ? (r_step + STEP_W'(1)) : '0;

  power_seq_rom u_rom (
    .i_idx    (w_rom_idx),
    .o_step_c (w_rom)
  );

`ifdef POWER_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo_cnt;

  // Counts cycles spent waiting in REQ; zero whenever outside REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_tmo_cnt <= '0;
    else if (r_state != ST_REQ) r_tmo_cnt <= '0;
    else                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end

  assign w_tmo_hit = (r_state == ST_REQ) && (r_tmo_cnt == TIMEOUT_CYCLES);
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_step     <= '0;
      r_delay_en <= 1'b0;
      r_delay_ms <= '0;
      r_ctrl     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_delay_en <= w_delay_en_nxt;
      r_delay_ms <= w_delay_ms_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) w_state_nxt = ST_REQ;
        ST_REQ: begin
          if (bus.delay_fin)
            w_state_nxt = (r_step == LAST_STEP) ? ST_DONE : ST_GAP;
          else if (w_tmo_hit)
            w_state_nxt = ST_ERR;
        end
        ST_GAP:  w_state_nxt = ST_REQ;
        ST_DONE: w_state_nxt = ST_DONE;
        ST_ERR:  w_state_nxt = ST_ERR;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next values for the registered outputs; GAP guarantees delay_en drops for one cycle
  always_comb begin
    w_step_nxt     = r_step;
    w_delay_en_nxt = r_delay_en;
    w_delay_ms_nxt = r_delay_ms;
    w_ctrl_nxt     = r_ctrl;
    w_busy_nxt     = (w_state_nxt == ST_REQ) || (w_state_nxt == ST_GAP);
    w_done_nxt     = (w_state_nxt == ST_DONE);
    w_err_nxt      = (w_state_nxt == ST_ERR);
    if (bus.abort) begin
      w_step_nxt     = '0;
      w_delay_en_nxt = 1'b0;
      w_delay_ms_nxt = '0;
      w_ctrl_nxt     = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            w_step_nxt     = '0;
            w_delay_en_nxt = 1'b1;
            w_delay_ms_nxt = w_rom.ms;
            w_ctrl_nxt     = w_rom.ctrl;
          end
        end
        ST_REQ: begin
          if (bus.delay_fin) begin
            w_delay_en_nxt = 1'b0;
          end else if (w_tmo_hit) begin
            w_delay_en_nxt = 1'b0;
            w_delay_ms_nxt = '0;
            w_ctrl_nxt     = '0;
          end
        end
        ST_GAP: begin
          w_step_nxt     = w_rom_idx;
          w_delay_en_nxt = 1'b1;
          w_delay_ms_nxt = w_rom.ms;
          w_ctrl_nxt     = w_rom.ctrl;
        end
        ST_DONE, ST_ERR: ;
        default: begin
          w_step_nxt     = '0;
          w_delay_en_nxt = 1'b0;
          w_delay_ms_nxt = '0;
          w_ctrl_nxt     = '0;
        end
      endcase
    end
  end

  assign bus.delay_en = r_delay_en;
  assign bus.delay_ms = r_delay_ms;
  assign bus.ctrl_out = r_ctrl;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_power_seq.sv
// Scoreboard bench for power_seq: expected requests queued by stimulus, checked by a monitor.
module tb_power_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  power_seq_if bus ();

  power_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [11:0] ms;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic model_on = 1'b1;
  logic man_fin  = 1'b0;

  logic [3:0]  tb_ctrl [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
  logic [11:0] tb_ms   [4] = '{12'd1, 12'd100, 12'd20, 12'd100};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_seq(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.ctrl = tb_ctrl[i];
      e.ms   = tb_ms[i];
      q.push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_req(input logic [3:0] c, input bit need_fin, input string nm);
    int k;
    bit ok;
    k  = 0;
    ok = 1'b0;
    while (!ok && k < 500) begin
      tick();
      k++;
      ok = bus.delay_en && (bus.ctrl_out == c) && (!need_fin || bus.delay_fin);
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    int k;
    bit ok;
    k  = 0;
    ok = 1'b0;
    while (!ok && k < 500) begin
      tick();
      k++;
      ok = bus.done;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  // Delay generator model: raises delay_fin on the 5th cycle of a request
  initial begin
    int  cnt;
    cnt           = 0;
    bus.delay_fin = 1'b0;
    forever begin
      @(negedge clk);
      if (model_on && bus.delay_en) cnt++;
      else                          cnt = 0;
      bus.delay_fin = model_on ? (cnt == 5) : man_fin;
    end
  end

  // Monitor: pops an expectation on each new request, checks hold and gap length
  initial begin
    exp_t cur;
    bit   have_cur;
    logic prev_en;
    bit   low_valid;
    int   low_cnt;
    have_cur  = 1'b0;
    prev_en   = 1'b0;
    low_valid = 1'b0;
    low_cnt   = 0;
    forever begin
      @(negedge clk);
      if (bus.delay_en && !prev_en) begin
        if (low_valid) chk("gap_len", 32'(low_cnt), 32'd1);
        low_valid = 1'b0;
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_req: ctrl %0h ms %0d with no pending expectation", bus.ctrl_out, bus.delay_ms);
          have_cur = 1'b0;
        end else begin
          cur      = q.pop_front();
          have_cur = 1'b1;
          chk("req_ctrl", 32'(bus.ctrl_out), 32'(cur.ctrl));
          chk("req_ms", 32'(bus.delay_ms), 32'(cur.ms));
        end
      end else if (bus.delay_en && have_cur) begin
        chk("hold_ctrl", 32'(bus.ctrl_out), 32'(cur.ctrl));
        chk("hold_ms", 32'(bus.delay_ms), 32'(cur.ms));
      end
      if (!bus.delay_en && prev_en) begin
        low_valid = bus.busy;
        low_cnt   = 1;
      end else if (!bus.delay_en && low_valid) begin
        if (bus.busy) low_cnt++;
        else          low_valid = 1'b0;
      end
      prev_en = bus.delay_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n     = 1'b0;
    repeat (3) tick();
    chk("rst_ctrl", 32'(bus.ctrl_out), 32'd0);
    chk("rst_en",   32'(bus.delay_en), 32'd0);
    chk("rst_ms",   32'(bus.delay_ms), 32'd0);
    chk("rst_busy", 32'(bus.busy),     32'd0);
    chk("rst_done", 32'(bus.done),     32'd0);
    chk("rst_err",  32'(bus.err),      32'd0);
    rst_n = 1'b1;
    tick();

    // Full sequence with delay model
    push_seq(4);
    pulse_start();
    wait_done("seq_done");
    chk("done_ctrl", 32'(bus.ctrl_out), 32'hF);
    chk("done_en",   32'(bus.delay_en), 32'd0);
    chk("done_busy", 32'(bus.busy),     32'd0);
    chk("done_err",  32'(bus.err),      32'd0);

    // delay_fin and start in DONE are ignored
    model_on = 1'b0;
    man_fin  = 1'b1;
    tick();
    man_fin   = 1'b0;
    bus.start = 1'b1;
    repeat (3) tick();
    bus.start = 1'b0;
    tick();
    chk("done_hold",      32'(bus.done),     32'd1);
    chk("done_hold_ctrl", 32'(bus.ctrl_out), 32'hF);
    chk("done_hold_en",   32'(bus.delay_en), 32'd0);
    chk("done_hold_busy", 32'(bus.busy),     32'd0);

    // abort leaves DONE
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_done_done", 32'(bus.done),     32'd0);
    chk("abort_done_ctrl", 32'(bus.ctrl_out), 32'd0);

    // delay_fin in IDLE is ignored
    man_fin = 1'b1;
    tick();
    man_fin = 1'b0;
    repeat (2) tick();
    chk("idle_fin_busy", 32'(bus.busy),     32'd0);
    chk("idle_fin_en",   32'(bus.delay_en), 32'd0);
    chk("idle_fin_ctrl", 32'(bus.ctrl_out), 32'd0);

    // abort wins over delay_fin during step 2
    model_on = 1'b1;
    push_seq(3);
    pulse_start();
    wait_req(4'b0111, 1'b1, "s2_fin_seen");
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_s2_ctrl", 32'(bus.ctrl_out), 32'd0);
    chk("abort_s2_en",   32'(bus.delay_en), 32'd0);
    chk("abort_s2_ms",   32'(bus.delay_ms), 32'd0);
    chk("abort_s2_busy", 32'(bus.busy),     32'd0);
    chk("abort_s2_done", 32'(bus.done),     32'd0);

    // Reset mid step 1, then restart from step 0
    push_seq(2);
    pulse_start();
    wait_req(4'b0011, 1'b0, "s1_seen");
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 32'(bus.ctrl_out), 32'd0);
    chk("midrst_en",   32'(bus.delay_en), 32'd0);
    chk("midrst_ms",   32'(bus.delay_ms), 32'd0);
    chk("midrst_busy", 32'(bus.busy),     32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    push_seq(4);
    pulse_start();
    wait_done("restart_done");
    chk("restart_ctrl", 32'(bus.ctrl_out), 32'hF);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;

    // No delay_fin: REQ holds, no error without the timeout option
    model_on = 1'b0;
    man_fin  = 1'b0;
    push_seq(1);
    pulse_start();
    repeat (200) tick();
    chk("stall_busy", 32'(bus.busy),     32'd1);
    chk("stall_en",   32'(bus.delay_en), 32'd1);
    chk("stall_ctrl", 32'(bus.ctrl_out), 32'h1);
    chk("stall_ms",   32'(bus.delay_ms), 32'd1);
    chk("stall_err",  32'(bus.err),      32'd0);
    chk("stall_done", 32'(bus.done),     32'd0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("final_ctrl", 32'(bus.ctrl_out), 32'd0);
    chk("final_busy", 32'(bus.busy),     32'd0);
    chk("queue_empty", 32'(q.size()),    32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
